// File: rtl/cpu_step_sequencer_if.sv
// Host/cluster/observer bundle for the stepping sequencer.
// master = host + cluster side, slave = sequencer.
interface cpu_step_sequencer_if #(
  parameter int VEC_W = 1894,
  parameter int CNT_W = 32
);
  logic             load_valid;
  logic             load_ready;
  logic [VEC_W-1:0] load_data;
  logic             step_req;
  logic             run;
  logic             halt;
  logic [CNT_W-1:0] max_steps;
  logic [VEC_W-1:0] nl_in;
  logic [VEC_W-1:0] nl_out;
  logic             obs_valid;
  logic             obs_ready;
  logic             busy;
  logic             limit_hit;
  logic [CNT_W-1:0] step_count;

  modport master (
    output load_valid, load_data, step_req, run, halt,
    output max_steps, nl_out, obs_ready,
    input  load_ready, nl_in, obs_valid, busy,
    input  limit_hit, step_count
  );

  modport slave (
    input  load_valid, load_data, step_req, run, halt,
    input  max_steps, nl_out, obs_ready,
    output load_ready, nl_in, obs_valid, busy,
    output limit_hit, step_count
  );
endinterface

// File: rtl/cpu_step_sequencer.sv
// Steps a combinational next-state cluster: hold state, wait a
// fixed settle window, commit the cluster output, publish it.
module cpu_step_sequencer #(
  parameter int VEC_W       = 1894,
  parameter int EVAL_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  cpu_step_sequencer_if.slave io
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    PUBLISH
  } fsm_e;

  localparam int EW =
    (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
  localparam logic [EW-1:0] EVAL_LAST =
    EW'(EVAL_CYCLES - 1);

  fsm_e             fsm_q;
  logic [VEC_W-1:0] state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             lim_q;
  logic             lim_d;
  logic [EW-1:0]    ecnt_q;
  logic             lim_eff;
  logic             start;
  logic             resume;

  // a same-cycle load clears the limit before the start decision
  assign lim_eff = io.load_valid ? 1'b0 : lim_q;
  assign start   = (io.step_req | io.run) & ~io.halt & ~lim_eff;
  assign resume  = io.run & ~io.halt & ~lim_q;

  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign lim_d = lim_q |
    ((io.max_steps != '0) & (cnt_d == io.max_steps));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      lim_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (io.load_valid) begin
            state_q <= io.load_data;
            cnt_q   <= '0;
            lim_q   <= 1'b0;
          end
          if (start) begin
            fsm_q  <= EVAL;
            ecnt_q <= EVAL_LAST;
          end
        end
        EVAL: begin
          if (ecnt_q == '0) begin
            state_q <= io.nl_out;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            fsm_q   <= PUBLISH;
          end else begin
            ecnt_q <= ecnt_q - 1'b1;
          end
        end
        PUBLISH: begin
          if (io.obs_ready) begin
            if (resume) begin
              fsm_q  <= EVAL;
              ecnt_q <= EVAL_LAST;
            end else begin
              fsm_q <= IDLE;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign io.load_ready = (fsm_q == IDLE);
  assign io.busy       = (fsm_q != IDLE);
  assign io.obs_valid  = (fsm_q == PUBLISH);
  assign io.nl_in      = state_q;
  assign io.limit_hit  = lim_q;
  assign io.step_count = cnt_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Bench for cpu_step_sequencer: table vectors, directed corner
// sequences and a randomized run against a transaction model.
module tb_cpu_step_sequencer;

  localparam int VEC_W = 1894;
  localparam int EVAL_CYCLES = 4;
  localparam int CNT_W = 32;

  typedef logic [VEC_W-1:0] vec_t;

  typedef struct {
    int n_steps;
    int max;
    int exp_cnt;
    bit exp_lim;
    bit exp_inv;
  } tv_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cpu_step_sequencer_if #(
    .VEC_W(VEC_W),
    .CNT_W(CNT_W)
  ) bus ();

  cpu_step_sequencer #(
    .VEC_W(VEC_W),
    .EVAL_CYCLES(EVAL_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(bus)
  );

  always #5 clk = ~clk;

  // cluster stand-in: next state is the bitwise inverse
  assign bus.nl_out = ~bus.nl_in;

  int vecs = 0;
  int fails = 0;

  vec_t m_state;
  int   m_cnt;
  bit   m_lim;
  int   m_max;
  bit   prev_v;

  function automatic vec_t f(vec_t x);
    return ~x;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < VEC_W; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkv(string nm, vec_t act, vec_t exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got low64 %h want low64 %h",
               nm, act[63:0], exp[63:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.load_valid = 1'b0;
    bus.step_req   = 1'b0;
    bus.run        = 1'b0;
    bus.halt       = 1'b0;
    bus.obs_ready  = 1'b1;
  endtask

  task automatic do_load(vec_t d);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_pub(output int lat);
    lat = 0;
    while (!bus.obs_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!bus.obs_valid) begin
      vecs++;
      fails++;
      $display("FAIL wait_pub: got timeout want obs_valid");
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    if (bus.busy) begin
      vecs++;
      fails++;
      $display("FAIL wait_idle: got busy want idle");
    end
  endtask

  task automatic count_pubs(input int cyc, output int pubs);
    pubs = 0;
    for (int c = 0; c < cyc; c++) begin
      tick();
      if (bus.obs_valid) pubs++;
    end
  endtask

  // transaction-level monitor: each new publish advances the model
  task automatic mon(input int cyc, input bit drain,
                     output int pubs);
    int c;
    pubs = 0;
    prev_v = bus.obs_valid;
    c = 0;
    while (c < cyc || (drain && bus.busy && c < cyc + 300)) begin
      tick();
      c++;
      if (bus.obs_valid && !prev_v) begin
        chk("pub_allowed", 64'(m_lim), 64'd0);
        m_state = f(m_state);
        m_cnt++;
        if (m_max != 0 && m_cnt == m_max) m_lim = 1'b1;
        chkv("pub_state", bus.nl_in, m_state);
        chk("pub_count", 64'(bus.step_count), 64'(m_cnt));
        chk("pub_limit", 64'(bus.limit_hit), 64'(m_lim));
        pubs++;
      end else if (bus.obs_valid) begin
        chkv("pub_hold", bus.nl_in, m_state);
      end
      prev_v = bus.obs_valid;
      bus.obs_ready = ($urandom_range(0, 3) != 0);
    end
    if (drain && bus.busy) begin
      vecs++;
      fails++;
      $display("FAIL mon_drain: got busy want idle");
    end
    bus.obs_ready = 1'b1;
  endtask

  tv_t  tab[7];
  vec_t a;
  vec_t b;
  vec_t held;
  int   lat;
  int   pubs;
  bit   lim_before;

  initial begin
    tab[0] = '{1, 0, 1, 1'b0, 1'b1};
    tab[1] = '{2, 0, 2, 1'b0, 1'b0};
    tab[2] = '{3, 2, 2, 1'b1, 1'b0};
    tab[3] = '{1, 1, 1, 1'b1, 1'b1};
    tab[4] = '{4, 3, 3, 1'b1, 1'b1};
    tab[5] = '{0, 0, 0, 1'b0, 1'b0};
    tab[6] = '{5, 2, 2, 1'b1, 1'b0};

    idle_in();
    bus.load_data = '0;
    bus.max_steps = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chkv("rst_nl_in", bus.nl_in, '0);
    chk("rst_count", 64'(bus.step_count), 64'd0);
    chk("rst_limit", 64'(bus.limit_hit), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_obs_valid", 64'(bus.obs_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_load_ready", 64'(bus.load_ready), 64'd1);

    // load then single step: latency and result
    a = rnd_vec();
    do_load(a);
    chkv("load_state", bus.nl_in, a);
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    wait_pub(lat);
    chk("step_latency", 64'(lat + 1), 64'(EVAL_CYCLES + 1));
    chkv("step_state", bus.nl_in, ~a);
    chk("step_count", 64'(bus.step_count), 64'd1);
    tick();
    chk("step_idle", 64'(bus.busy), 64'd0);
    chk("step_load_ready", 64'(bus.load_ready), 64'd1);

    // simultaneous load and step_req
    b = rnd_vec();
    bus.load_valid = 1'b1;
    bus.load_data  = b;
    bus.step_req   = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.step_req   = 1'b0;
    chk("ldstep_busy", 64'(bus.busy), 64'd1);
    chkv("ldstep_loaded", bus.nl_in, b);
    wait_pub(lat);
    chkv("ldstep_state", bus.nl_in, ~b);
    chk("ldstep_count", 64'(bus.step_count), 64'd1);
    tick();
    wait_idle();

    // free run with backpressure on the second publish
    a = rnd_vec();
    do_load(a);
    bus.run = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      wait_pub(lat);
      chk("run_period", 64'(lat), 64'(EVAL_CYCLES));
      chkv("run_state", bus.nl_in, (k % 2 == 1) ? ~a : a);
      chk("run_count", 64'(bus.step_count), 64'(k));
      if (k == 2) begin
        held = bus.nl_in;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("bp_valid", 64'(bus.obs_valid), 64'd1);
          chkv("bp_hold", bus.nl_in, held);
          chk("bp_count", 64'(bus.step_count), 64'd2);
        end
        bus.obs_ready = 1'b1;
      end
      tick();
      if (k == 1) bus.obs_ready = 1'b0;
    end
    bus.run = 1'b0;
    wait_idle();
    chk("run_final_count", 64'(bus.step_count), 64'd5);

    // step limit with run held high
    a = rnd_vec();
    do_load(a);
    bus.max_steps = 32'd3;
    bus.run = 1'b1;
    count_pubs(60, pubs);
    chk("lim_pubs", 64'(pubs), 64'd3);
    chk("lim_hit", 64'(bus.limit_hit), 64'd1);
    chk("lim_idle", 64'(bus.busy), 64'd0);
    chk("lim_count", 64'(bus.step_count), 64'd3);
    chkv("lim_state", bus.nl_in, ~a);
    bus.run = 1'b0;
    b = rnd_vec();
    do_load(b);
    chk("lim_clr_hit", 64'(bus.limit_hit), 64'd0);
    chk("lim_clr_count", 64'(bus.step_count), 64'd0);
    chkv("lim_clr_state", bus.nl_in, b);
    bus.max_steps = '0;

    // halt raised two cycles into EVAL
    a = rnd_vec();
    do_load(a);
    bus.run = 1'b1;
    tick();
    tick();
    bus.halt = 1'b1;
    count_pubs(40, pubs);
    chk("halt_pubs", 64'(pubs), 64'd1);
    chk("halt_idle", 64'(bus.busy), 64'd0);
    chk("halt_count", 64'(bus.step_count), 64'd1);
    chkv("halt_state", bus.nl_in, ~a);
    bus.run  = 1'b0;
    bus.halt = 1'b0;

    // table of single-step runs
    foreach (tab[i]) begin
      a = rnd_vec();
      do_load(a);
      bus.max_steps = 32'(tab[i].max);
      for (int n = 0; n < tab[i].n_steps; n++) begin
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        for (int w = 0; w < EVAL_CYCLES + 4; w++) begin
          if (!bus.obs_valid) tick();
        end
        if (bus.obs_valid) tick();
        wait_idle();
      end
      chk("tab_count", 64'(bus.step_count), 64'(tab[i].exp_cnt));
      chk("tab_limit", 64'(bus.limit_hit), 64'(tab[i].exp_lim));
      chkv("tab_state", bus.nl_in, tab[i].exp_inv ? ~a : a);
    end
    bus.max_steps = '0;

    // async reset while publishing
    a = rnd_vec();
    do_load(a);
    bus.obs_ready = 1'b0;
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    wait_pub(lat);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_obs_drop", 64'(bus.obs_valid), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.obs_ready = 1'b1;
    tick();
    chkv("arst_nl_in", bus.nl_in, '0);
    chk("arst_count", 64'(bus.step_count), 64'd0);
    chk("arst_busy_after", 64'(bus.busy), 64'd0);
    chk("arst_obs_after", 64'(bus.obs_valid), 64'd0);

    // randomized loads, steps and runs against the model
    m_state = '0;
    m_cnt = 0;
    m_lim = 1'b0;
    m_max = 0;
    for (int it = 0; it < 40; it++) begin
      int op;
      op = (it == 0) ? 0 : int'($urandom_range(0, 3));
      if (op == 0) begin
        m_max = ($urandom_range(0, 2) == 0) ?
                0 : int'($urandom_range(1, 4));
        bus.max_steps = 32'(m_max);
        a = rnd_vec();
        do_load(a);
        m_state = a;
        m_cnt = 0;
        m_lim = 1'b0;
        chkv("rnd_load", bus.nl_in, m_state);
      end else if (op == 1) begin
        lim_before = m_lim;
        bus.step_req = 1'b1;
        tick();
        bus.step_req = 1'b0;
        mon(0, 1'b1, pubs);
        chk("rnd_step_pubs", 64'(pubs), lim_before ? 64'd0 : 64'd1);
      end else begin
        bus.run = 1'b1;
        mon(int'($urandom_range(5, 40)), 1'b0, pubs);
        bus.run = 1'b0;
        mon(0, 1'b1, pubs);
      end
      chk("rnd_count", 64'(bus.step_count), 64'(m_cnt));
      chk("rnd_limit", 64'(bus.limit_hit), 64'(m_lim));
      chkv("rnd_state", bus.nl_in, m_state);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
